// File: rtl/microwave_cook_timer.sv
// Cook-time countdown beside the microwave controller: counts preset seconds while heating, pulses done at zero.
// Optional +30 s button is compiled in with `define MW_TIMER_ADD30_EN.
module microwave_cook_timer #(
  parameter int unsigned TW          = 8,
  parameter int unsigned CLK_PER_SEC = 100
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    states,
  input  logic          time_load,
  input  logic [TW-1:0] time_sec,
  input  logic          cancel,
  input  logic          add30,
  output logic          done,
  output logic [TW-1:0] remaining,
  output logic          magnetron_on,
  output logic          paused
);

  localparam int unsigned PW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_PER_SEC - 1);
  localparam logic [TW-1:0] ADD_SEC   = TW'(30);
`ifdef MW_TIMER_ADD30_EN
  localparam bit ADD30_EN = 1'b1;
`else
  localparam bit ADD30_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    COOKING = 2'd2,
    PAUSED  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] rem_q, rem_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          done_q, done_d;
  logic          mag_q, mag_d;
  logic          paused_q, paused_d;

  logic          heat_ok;
  logic          tick;
  logic          add_en;
  logic          last_tick;
  logic          load_ok;
  logic          start_unused;
  logic [TW-1:0] rem_dec;
  logic [TW-1:0] rem_plus;
  logic [TW-1:0] rem_dec_plus;

  // Saturating +30 s
  function automatic logic [TW-1:0] sat_add30(input logic [TW-1:0] base);
    logic [TW:0] sum;
    sum = {1'b0, base} + {1'b0, ADD_SEC};
    return sum[TW] ? {TW{1'b1}} : sum[TW-1:0];
  endfunction

  assign start_unused = states[3];
  assign heat_ok      = states[2] & states[1] & ~states[0];
  assign tick         = (presc_q == PRESC_MAX);
  assign add_en       = ADD30_EN & add30;
  assign load_ok      = time_load & (time_sec != '0);
  assign rem_dec      = (rem_q != '0) ? rem_q - TW'(1) : '0;
  assign rem_plus     = sat_add30(rem_q);
  assign rem_dec_plus = sat_add30(rem_dec);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      presc_q  <= '0;
      done_q   <= 1'b0;
      mag_q    <= 1'b0;
      paused_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      presc_q  <= presc_d;
      done_q   <= done_d;
      mag_q    <= mag_d;
      paused_q <= paused_d;
    end
  end

  // Next state, countdown and prescaler
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    presc_d   = presc_q;
    last_tick = 1'b0;
    if (cancel) begin
      state_d = IDLE;
      rem_d   = '0;
      presc_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          presc_d = '0;
          if (load_ok) begin
            state_d = ARMED;
            rem_d   = time_sec;
          end else if (add_en) begin
            state_d = ARMED;
            rem_d   = ADD_SEC;
          end
        end
        ARMED: begin
          if (load_ok)     rem_d = time_sec;
          else if (add_en) rem_d = rem_plus;
          if (heat_ok) begin
            state_d = COOKING;
            presc_d = '0;
          end
        end
        COOKING: begin
          if (!heat_ok) begin
            state_d = PAUSED;
            if (add_en) rem_d = rem_plus;
          end else if (tick) begin
            presc_d = '0;
            if (add_en) begin
              rem_d = rem_dec_plus;
            end else if (rem_q <= TW'(1)) begin
              // Final second expires: finish cooking
              rem_d     = '0;
              state_d   = IDLE;
              last_tick = (rem_q == TW'(1));
            end else begin
              rem_d = rem_dec;
            end
          end else begin
            presc_d = presc_q + PW'(1);
            if (add_en) rem_d = rem_plus;
          end
        end
        PAUSED: begin
          if (add_en) rem_d = rem_plus;
          if (heat_ok) state_d = COOKING;
        end
        default: begin
          state_d = IDLE;
          rem_d   = '0;
          presc_d = '0;
        end
      endcase
    end
  end

  // Registered outputs follow the next state
  always_comb begin
    done_d   = last_tick;
    mag_d    = (state_d == COOKING);
    paused_d = (state_d == PAUSED);
  end

  assign done         = done_q;
  assign remaining    = rem_q;
  assign magnetron_on = mag_q;
  assign paused       = paused_q;

endmodule

// File: tb/tb_microwave_cook_timer.sv
// Scoreboard bench for microwave_cook_timer (TW=8, CLK_PER_SEC=4); follows MW_TIMER_ADD30_EN if defined.
module tb_microwave_cook_timer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] states = 4'b0000;
  logic       time_load = 1'b0;
  logic [7:0] time_sec = 8'd0;
  logic       cancel = 1'b0;
  logic       add30 = 1'b0;
  logic       done;
  logic [7:0] remaining;
  logic       magnetron_on;
  logic       paused;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  typedef struct {
    string      tag;
    int         cyc;
    logic [7:0] rem;
    logic       done;
    logic       mag;
    logic       paused;
  } snap_t;

  snap_t snap_q[$];
  int    done_q[$];

`ifdef MW_TIMER_ADD30_EN
  localparam bit A30 = 1'b1;
`else
  localparam bit A30 = 1'b0;
`endif

  microwave_cook_timer #(.TW(8), .CLK_PER_SEC(4)) dut (
    .clk(clk), .reset(reset), .states(states), .time_load(time_load),
    .time_sec(time_sec), .cancel(cancel), .add30(add30), .done(done),
    .remaining(remaining), .magnetron_on(magnetron_on), .paused(paused)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Position just after edge n-1 so inputs are sampled at edge n
  task automatic drive_at(input int n);
    if (cyc > n - 1) begin
      $display("FAIL sched: at cycle %0d, wanted slot %0d", cyc, n);
      $fatal(1);
    end
    while (cyc < n - 1) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic exp_at(input string tag, input int n, input int rem, input bit d, input bit m, input bit p);
    snap_t s;
    s.tag = tag; s.cyc = n; s.rem = 8'(rem); s.done = d; s.mag = m; s.paused = p;
    snap_q.push_back(s);
  endtask

  // Monitor: compare scheduled snapshots and every done pulse
  always @(negedge clk) begin
    snap_t s;
    while (snap_q.size() > 0 && snap_q[0].cyc < cyc) begin
      s = snap_q.pop_front();
      total++; bad++;
      $display("FAIL %s: snapshot for cycle %0d missed", s.tag, s.cyc);
    end
    while (snap_q.size() > 0 && snap_q[0].cyc == cyc) begin
      s = snap_q.pop_front();
      total++;
      if (remaining !== s.rem || done !== s.done || magnetron_on !== s.mag || paused !== s.paused) begin
        bad++;
        $display("FAIL %s @%0d: got rem=%0d done=%b mag=%b paused=%b, want rem=%0d done=%b mag=%b paused=%b",
                 s.tag, cyc, remaining, done, magnetron_on, paused, s.rem, s.done, s.mag, s.paused);
      end
    end
    if (done === 1'b1) begin
      total++;
      if (done_q.size() == 0) begin
        bad++;
        $display("FAIL done_unexp @%0d: got done=1, want none", cyc);
      end else if (done_q[0] != cyc) begin
        bad++;
        $display("FAIL done_cyc: got done at %0d, want %0d", cyc, done_q[0]);
        void'(done_q.pop_front());
      end else begin
        void'(done_q.pop_front());
      end
    end else if (done_q.size() > 0 && done_q[0] < cyc) begin
      total++; bad++;
      $display("FAIL done_miss: got none, want done at %0d", done_q[0]);
      void'(done_q.pop_front());
    end
  end

  initial begin
    // Reset, then reset again mid-cook
    drive_at(1); reset = 1'b1;
    exp_at("rst_init", 2, 0, 0, 0, 0);
    drive_at(3); reset = 1'b0;
    drive_at(4); time_load = 1'b1; time_sec = 8'd5;
    exp_at("load5", 4, 5, 0, 0, 0);
    drive_at(5); time_load = 1'b0; states = 4'b0110;
    exp_at("cook5", 5, 5, 0, 1, 0);
    drive_at(7); reset = 1'b1;
    exp_at("rst_mid", 7, 0, 0, 0, 0);
    exp_at("rst_hold", 8, 0, 0, 0, 0);
    drive_at(9); reset = 1'b0; states = 4'b0000;
    exp_at("rst_idle", 9, 0, 0, 0, 0);

    // Load 3, uninterrupted cook; load during COOKING ignored
    drive_at(10); time_load = 1'b1; time_sec = 8'd3;
    exp_at("arm3", 10, 3, 0, 0, 0);
    drive_at(11); time_load = 1'b0; states = 4'b0110;
    exp_at("e0", 11, 3, 0, 1, 0);
    exp_at("pre_tick", 14, 3, 0, 1, 0);
    exp_at("tick1", 15, 2, 0, 1, 0);
    drive_at(17); time_load = 1'b1; time_sec = 8'd9;
    exp_at("ld_ign", 17, 2, 0, 1, 0);
    drive_at(18); time_load = 1'b0; time_sec = 8'd0;
    exp_at("tick2", 19, 1, 0, 1, 0);
    exp_at("done3", 23, 0, 1, 0, 0);
    done_q.push_back(23);
    exp_at("done_drop", 24, 0, 0, 0, 0);
    drive_at(25); states = 4'b0000;

    // Zero load ignored; heat in IDLE does nothing
    drive_at(26); time_load = 1'b1; time_sec = 8'd0;
    exp_at("zero_ld", 26, 0, 0, 0, 0);
    drive_at(27); time_load = 1'b0; states = 4'b0110;
    exp_at("idle_heat", 28, 0, 0, 0, 0);
    drive_at(29); states = 4'b0000;

    // Door open mid-second, error state while paused, resume
    drive_at(30); time_load = 1'b1; time_sec = 8'd3;
    drive_at(31); time_load = 1'b0; states = 4'b0110;
    exp_at("d_cook", 31, 3, 0, 1, 0);
    exp_at("d_tick", 35, 2, 0, 1, 0);
    drive_at(38); states = 4'b0000;
    exp_at("pause", 38, 2, 0, 0, 1);
    exp_at("pause_hold", 48, 2, 0, 0, 1);
    drive_at(50); states = 4'b1111;
    exp_at("err_hold", 52, 2, 0, 0, 1);
    exp_at("pause_end", 57, 2, 0, 0, 1);
    drive_at(58); states = 4'b0110;
    exp_at("resume", 58, 2, 0, 1, 0);
    exp_at("res_pre", 59, 2, 0, 1, 0);
    exp_at("res_tick", 60, 1, 0, 1, 0);
    exp_at("res_done", 64, 0, 1, 0, 0);
    done_q.push_back(64);
    drive_at(65); states = 4'b0000;

    // Cancel on the final tick
    drive_at(66); time_load = 1'b1; time_sec = 8'd1;
    drive_at(67); time_load = 1'b0; states = 4'b0110;
    exp_at("c_cook", 70, 1, 0, 1, 0);
    drive_at(71); cancel = 1'b1;
    exp_at("cancel", 71, 0, 0, 0, 0);
    drive_at(72); cancel = 1'b0;
    exp_at("cancel_idle", 72, 0, 0, 0, 0);
    drive_at(73); states = 4'b0000;

    // Heat lost on the final tick: pause, no done; then cancel from PAUSED
    drive_at(74); time_load = 1'b1; time_sec = 8'd1;
    drive_at(75); time_load = 1'b0; states = 4'b0110;
    exp_at("h_pre", 78, 1, 0, 1, 0);
    drive_at(79); states = 4'b0000;
    exp_at("h_pause", 79, 1, 0, 0, 1);
    exp_at("h_hold", 80, 1, 0, 0, 1);
    drive_at(81); cancel = 1'b1;
    exp_at("p_cancel", 81, 0, 0, 0, 0);
    drive_at(82); cancel = 1'b0;

    // add30 in IDLE and ARMED (saturation)
    drive_at(84); add30 = 1'b1;
    exp_at("a_idle", 84, A30 ? 30 : 0, 0, 0, 0);
    drive_at(85); add30 = 1'b0;
    drive_at(86); time_load = 1'b1; time_sec = 8'd240;
    exp_at("ld240", 86, 240, 0, 0, 0);
    drive_at(87); time_load = 1'b0; time_sec = 8'd0;
    drive_at(88); add30 = 1'b1;
    exp_at("a_sat", 88, A30 ? 255 : 240, 0, 0, 0);
    drive_at(89); add30 = 1'b0;
    drive_at(90); cancel = 1'b1;
    exp_at("a_cancel", 90, 0, 0, 0, 0);
    drive_at(91); cancel = 1'b0;

    // add30 together with the final tick
    drive_at(92); time_load = 1'b1; time_sec = 8'd1;
    drive_at(93); time_load = 1'b0; states = 4'b0110;
    exp_at("t_cook", 96, 1, 0, 1, 0);
    drive_at(97); add30 = 1'b1;
    if (A30) begin
      exp_at("t_add", 97, 30, 0, 1, 0);
    end else begin
      exp_at("t_add", 97, 0, 1, 0, 0);
      done_q.push_back(97);
    end
    drive_at(98); add30 = 1'b0; states = 4'b0000;
    exp_at("t_after", 98, A30 ? 30 : 0, 0, 0, A30);
    drive_at(99); cancel = 1'b1;
    exp_at("t_cancel", 99, 0, 0, 0, 0);
    drive_at(100); cancel = 1'b0;
    drive_at(105);

    while (snap_q.size() > 0) begin
      snap_t s;
      s = snap_q.pop_front();
      total++; bad++;
      $display("FAIL %s: snapshot for cycle %0d never checked", s.tag, s.cyc);
    end
    while (done_q.size() > 0) begin
      total++; bad++;
      $display("FAIL done_pending: got none, want done at %0d", done_q.pop_front());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

endmodule
